// File: rtl/mem_fill_arbiter.sv
// Block-refill sequencer shared by the I-cache and D-cache. Grants one miss at a
// time (D-cache wins ties), issues one read per cycle for the whole block, steers
// returning words into the granted cache and pulses that cache's done flag.
module mem_fill_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     icache_miss,
    input  logic [ADDR_W-1:0]        icache_miss_addr,
    input  logic                     dcache_miss,
    input  logic [ADDR_W-1:0]        dcache_miss_addr,
    output logic                     mem_enable,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_data_valid,
    input  logic [DATA_W-1:0]        mem_data_in,
    output logic [DATA_W-1:0]        fill_data,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     icache_fill_we,
    output logic                     dcache_fill_we,
    output logic                     icache_fill_done,
    output logic                     dcache_fill_done,
    output logic                     stall,
    output logic                     busy
);

    localparam int unsigned       CNT_W      = $clog2(WORDS);
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(WORDS - 1);
    localparam logic [CNT_W:0]    ALL_ISSUED = (CNT_W + 1)'(WORDS);
    // Clears the byte offset within a block (WORDS words of two bytes each).
    localparam logic [ADDR_W-1:0] BLK_MASK   = ~ADDR_W'(2 * WORDS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic               grant_d_q, grant_d_d;       // 1: D-cache owns the refill
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic               issue_last_q, issue_last_d; // all words of the block issued
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [CNT_W:0]     issued;
    logic               accept;

    // Words requested so far in this refill; a return is only credible if it has a
    // matching outstanding read, which drops data still in flight from before a reset.
    assign issued = issue_last_q ? ALL_ISSUED : {1'b0, issue_cnt_q};
    assign accept = mem_data_valid && (state_q == StIssue || state_q == StWait) &&
                    ({1'b0, recv_cnt_q} < issued);

    // Stall is combinational so the PC freezes in the miss cycle itself.
    assign busy  = (state_q != StIdle);
    assign stall = icache_miss | dcache_miss | busy;

    // State, grant, block base and word counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_d_q    <= 1'b0;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            issue_last_q <= 1'b0;
            recv_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_d_q    <= grant_d_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            issue_last_q <= issue_last_d;
            recv_cnt_q   <= recv_cnt_d;
        end
    end

    // Next-state logic, read issue and fill steering.
    always_comb begin
        state_d          = state_q;
        grant_d_d        = grant_d_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        issue_last_d     = issue_last_q;
        recv_cnt_d       = recv_cnt_q;
        mem_enable       = 1'b0;
        mem_addr         = '0;
        fill_data        = '0;
        fill_word        = '0;
        icache_fill_we   = 1'b0;
        dcache_fill_we   = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dcache_miss || icache_miss) begin
                    grant_d_d    = dcache_miss;
                    base_d       = (dcache_miss ? dcache_miss_addr : icache_miss_addr) &
                                   BLK_MASK;
                    issue_cnt_d  = '0;
                    issue_last_d = 1'b0;
                    recv_cnt_d   = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                mem_enable = 1'b1;
                mem_addr   = base_q | ADDR_W'({issue_cnt_q, 1'b0});
                if (issue_cnt_q == LAST_IDX) begin
                    issue_last_d = 1'b1;
                    state_d      = StWait;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            StWait: begin
            end
            StDone: begin
                // Requester still holds its miss here, so no new grant this cycle.
                icache_fill_done = !grant_d_q;
                dcache_fill_done = grant_d_q;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            icache_fill_we = !grant_d_q;
            dcache_fill_we = grant_d_q;
            fill_word      = recv_cnt_q;
            fill_data      = mem_data_in;
            if (recv_cnt_q == LAST_IDX) begin
                state_d = StDone;
            end else begin
                recv_cnt_d = recv_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomised scoreboard bench for mem_fill_arbiter with a fixed-latency memory model.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_miss_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_miss_addr = '0;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done;
    logic        stall, busy;

    logic        stray_v = 1'b0;
    logic [15:0] stray_d = '0;
    logic [3:0]  pv = '0;
    logic [15:0] pa [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_fill_seen = 0;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [15:0] val;
        logic [2:0]  word;
    } exp_t;

    exp_t q_iss[$];
    exp_t q_fill[$];
    exp_t q_done[$];

    mem_fill_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .mem_enable       (mem_enable),
        .mem_addr         (mem_addr),
        .mem_data_valid   (mem_data_valid),
        .mem_data_in      (mem_data_in),
        .fill_data        (fill_data),
        .fill_word        (fill_word),
        .icache_fill_we   (icache_fill_we),
        .dcache_fill_we   (dcache_fill_we),
        .icache_fill_done (icache_fill_done),
        .dcache_fill_done (dcache_fill_done),
        .stall            (stall),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h3C5A;
    endfunction

    // Memory: a read seen in cycle n returns its word in cycle n+4.
    assign mem_data_valid = pv[3] | stray_v;
    assign mem_data_in    = pv[3] ? mem_word(pa[3]) : stray_d;

    initial begin
        logic        ien;
        logic [15:0] iad;
        for (int i = 0; i < 4; i++) pa[i] = '0;
        forever begin
            @(negedge clk);
            ien = mem_enable;
            iad = mem_addr;
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = ien;
            pa[0] = iad;
        end
    end

    task automatic chk(input bit ok, input string name, input string act, input string exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s, wanted %s", name, act, exp);
        end
    endtask

    // Expected transactions of one refill whose miss is first seen in IDLE at cycle t.
    task automatic push_refill(input bit is_d, input logic [15:0] a, input int t,
                               input int n_iss, input int n_fill, input bit with_done);
        logic [15:0] base;
        exp_t e;
        base = a & 16'hFFF0;
        for (int k = 0; k < n_iss; k++) begin
            e = '{cyc: t + 1 + k, is_d: is_d, val: base + 16'(2 * k), word: 3'(k)};
            q_iss.push_back(e);
        end
        for (int k = 0; k < n_fill; k++) begin
            e = '{cyc: t + 5 + k, is_d: is_d, val: mem_word(base + 16'(2 * k)), word: 3'(k)};
            q_fill.push_back(e);
        end
        if (with_done) begin
            e = '{cyc: t + 13, is_d: is_d, val: '0, word: '0};
            q_done.push_back(e);
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_enable) begin
                if (q_iss.size() == 0) begin
                    chk(1'b0, "issue_unexpected", $sformatf("addr=%h cyc=%0d", mem_addr, cyc),
                        "no issue");
                end else begin
                    e = q_iss.pop_front();
                    chk(mem_addr === e.val && cyc == e.cyc, "issue",
                        $sformatf("addr=%h cyc=%0d", mem_addr, cyc),
                        $sformatf("addr=%h cyc=%0d", e.val, e.cyc));
                end
            end
            if (icache_fill_we || dcache_fill_we) begin
                n_fill_seen++;
                if (q_fill.size() == 0) begin
                    chk(1'b0, "fill_unexpected", $sformatf("iwe=%b dwe=%b word=%0d cyc=%0d",
                        icache_fill_we, dcache_fill_we, fill_word, cyc), "no fill");
                end else begin
                    e = q_fill.pop_front();
                    chk(icache_fill_we === !e.is_d && dcache_fill_we === e.is_d &&
                        fill_word === e.word && fill_data === e.val && cyc == e.cyc, "fill",
                        $sformatf("iwe=%b dwe=%b word=%0d data=%h cyc=%0d", icache_fill_we,
                                  dcache_fill_we, fill_word, fill_data, cyc),
                        $sformatf("iwe=%b dwe=%b word=%0d data=%h cyc=%0d", !e.is_d, e.is_d,
                                  e.word, e.val, e.cyc));
                end
            end
            if (icache_fill_done || dcache_fill_done) begin
                if (q_done.size() == 0) begin
                    chk(1'b0, "done_unexpected", $sformatf("idone=%b ddone=%b cyc=%0d",
                        icache_fill_done, dcache_fill_done, cyc), "no done");
                end else begin
                    e = q_done.pop_front();
                    chk(icache_fill_done === !e.is_d && dcache_fill_done === e.is_d &&
                        cyc == e.cyc, "done",
                        $sformatf("idone=%b ddone=%b cyc=%0d", icache_fill_done,
                                  dcache_fill_done, cyc),
                        $sformatf("idone=%b ddone=%b cyc=%0d", !e.is_d, e.is_d, e.cyc));
                end
            end
        end
    end

    // One clock; a requester drops its miss in the cycle after its done pulse.
    task automatic step();
        bit i_done, d_done;
        @(negedge clk);
        i_done = icache_fill_done;
        d_done = dcache_fill_done;
        @(posedge clk);
        #1;
        if (i_done) icache_miss = 1'b0;
        if (d_done) dcache_miss = 1'b0;
    endtask

    task automatic raise(input bit is_d, input logic [15:0] a);
        if (is_d) begin
            dcache_miss = 1'b1;
            dcache_miss_addr = a;
        end else begin
            icache_miss = 1'b1;
            icache_miss_addr = a;
        end
    endtask

    task automatic chk_drained(input string name);
        chk(q_iss.size() == 0 && q_fill.size() == 0 && q_done.size() == 0, name,
            $sformatf("pending iss=%0d fill=%0d done=%0d", q_iss.size(), q_fill.size(),
                      q_done.size()), "none pending");
    endtask

    // One or two refills. The second requester (other cache) rises k cycles after the
    // first; a tie goes to the D-cache, and a waiting request starts at the next IDLE.
    task automatic run_pair(input bit two, input bit first_d, input logic [15:0] a1,
                            input logic [15:0] a2, input int k, input int drop1);
        int t;
        int last;
        bit s1_d;
        logic [15:0] s1_a, s2_a;
        bit eb;
        t = cyc;
        if (two && k == 0 && !first_d) begin
            s1_d = 1'b1; s1_a = a2; s2_a = a1;
        end else begin
            s1_d = first_d; s1_a = a1; s2_a = a2;
        end
        push_refill(s1_d, s1_a, t, 8, 8, 1'b1);
        if (two) push_refill(!s1_d, s2_a, t + 14, 8, 8, 1'b1);
        last = two ? 29 : 15;
        for (int c = 0; c <= last; c++) begin
            if (c == 0) raise(first_d, a1);
            if (two && c == k) raise(!first_d, a2);
            if (!two && c == drop1) begin
                if (first_d) dcache_miss = 1'b0;
                else icache_miss = 1'b0;
            end
            #1;
            eb = (c >= 1 && c <= 13) || (two && c >= 15 && c <= 27);
            chk(busy === eb, "busy", $sformatf("%b at +%0d", busy, c), $sformatf("%b", eb));
            chk(stall === (eb | icache_miss | dcache_miss), "stall",
                $sformatf("%b at +%0d", stall, c),
                $sformatf("%b", eb | icache_miss | dcache_miss));
            step();
        end
        chk_drained("refill_drained");
    endtask

    initial begin
        logic [40:0] outs;
        logic [15:0] a1, a2;
        int t, mode, fd, n0;

        // Reset held with both misses up and stray data toggling.
        rst = 1'b0;
        icache_miss = 1'b1; icache_miss_addr = 16'h1111;
        dcache_miss = 1'b1; dcache_miss_addr = 16'h2222;
        step();
        for (int i = 0; i < 4; i++) begin
            stray_v = ~stray_v;
            stray_d = 16'($urandom);
            #1;
            outs = {mem_enable, mem_addr, fill_data, fill_word, icache_fill_we, dcache_fill_we,
                    icache_fill_done, dcache_fill_done, busy};
            chk(outs == '0, "reset_outputs", $sformatf("%h", outs), "0");
            chk(stall === 1'b1, "reset_stall", $sformatf("%b", stall), "1");
            step();
        end
        icache_miss = 1'b0; dcache_miss = 1'b0; stray_v = 1'b0;
        rst = 1'b1;
        #1;
        chk(stall === 1'b0 && busy === 1'b0, "post_reset_idle",
            $sformatf("stall=%b busy=%b", stall, busy), "stall=0 busy=0");
        step();
        chk(busy === 1'b0, "post_reset_busy", $sformatf("%b", busy), "0");

        // Plain I-cache refill.
        run_pair(1'b0, 1'b0, 16'h1236, 16'h0000, 0, -1);
        // Simultaneous I and D misses: D first, I two cycles after D's done pulse.
        run_pair(1'b1, 1'b0, 16'h0040, 16'h8008, 0, -1);
        // D requester gives up early; the refill still completes.
        run_pair(1'b0, 1'b1, 16'h4A52, 16'h0000, 0, 3);

        // Reset asserted mid-refill, released two cycles later with the miss held.
        t = cyc;
        push_refill(1'b0, 16'h3C7A, t, 6, 2, 1'b0);
        raise(1'b0, 16'h3C7A);
        for (int c = 0; c <= 6; c++) begin
            #1;
            chk(busy === (c >= 1), "busy_pre_reset", $sformatf("%b at +%0d", busy, c),
                $sformatf("%b", c >= 1));
            step();
        end
        rst = 1'b0;
        #1;
        chk(busy === 1'b0 && stall === 1'b1, "async_reset",
            $sformatf("busy=%b stall=%b", busy, stall), "busy=0 stall=1");
        step();
        step();
        rst = 1'b1;
        push_refill(1'b0, 16'h3C7A, cyc, 8, 8, 1'b1);
        for (int c = 0; c <= 15; c++) begin
            #1;
            chk(busy === (c >= 1 && c <= 13), "busy_restart", $sformatf("%b at +%0d", busy, c),
                $sformatf("%b", c >= 1 && c <= 13));
            step();
        end
        chk_drained("restart_drained");

        // Stray returns while idle must be ignored; the next refill starts at word 0.
        n0 = n_fill_seen;
        for (int i = 0; i < 4; i++) begin
            stray_v = 1'b1;
            stray_d = 16'($urandom);
            step();
        end
        stray_v = 1'b0;
        chk(n_fill_seen == n0 && busy === 1'b0, "stray_ignored",
            $sformatf("fills=%0d busy=%b", n_fill_seen - n0, busy), "fills=0 busy=0");
        run_pair(1'b0, 1'b0, 16'hBEEF, 16'h0000, 0, -1);

        // Random traffic.
        for (int it = 0; it < 16; it++) begin
            mode = int'($urandom_range(0, 3));
            fd   = int'($urandom_range(0, 1));
            a1   = 16'($urandom);
            a2   = 16'($urandom);
            case (mode)
                0: run_pair(1'b0, fd[0], a1, a2, 0, -1);
                1: run_pair(1'b1, fd[0], a1, a2, 0, -1);
                2: run_pair(1'b1, fd[0], a1, a2, int'($urandom_range(1, 12)), -1);
                default: run_pair(1'b0, fd[0], a1, a2, 0, int'($urandom_range(1, 12)));
            endcase
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                stray_v = 1'($urandom_range(0, 1));
                stray_d = 16'($urandom);
                step();
            end
            stray_v = 1'b0;
        end

        step();
        chk_drained("final_drained");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, wanted finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
